// File: rtl/dmem_responder_if.sv
// Request/response channels between the MEM stage and the data memory.
// master = MEM stage (initiator), slave = dmem_responder.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_wr, req_addr,
    output req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_wr, req_addr,
    input  req_wdata, req_be, resp_ready,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data memory responder: one request at a time, LATENCY edges to response.
// Ports: clk, rst (async high), bus (slave). Macro: DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic wr_q;
  logic [DEPTH_LOG2-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [3:0] be_q;
  logic mis_q;

  logic [31:0] mem [DEPTH];

  logic accept;
  logic do_write;
  logic addr_unused;

  assign addr_unused = ^bus.req_addr;

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  assign accept = bus.req_valid && (state_q == IDLE);

  // Misaligned requests (check build only) skip the array entirely.
  assign do_write = (state_q == WAIT) && (cnt_q == 4'd0)
                 && wr_q && !mis_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          valid_d = 1'b1;
          err_d   = mis_q;
          rdata_d = (wr_q || mis_q) ? 32'd0 : mem[idx_q];
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (accept) begin
      wr_q    <= bus.req_wr;
      idx_q   <= bus.req_addr[DEPTH_LOG2+1:2];
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else if (accept) begin
      mis_q <= |bus.req_addr[1:0];
    end
  end
`else
  assign mis_q = 1'b0;
`endif

  // No reset on the array; rst gating drops a store caught mid-reset.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the MEM-stage data port.
- Serves one load/store request at a time over valid/ready request and response channels, with a programmable wait-state latency.
- Word-organised storage with byte-lane write enables.
- Replaces the zero-latency combinational data memory when the pipeline gains stall support; the CPU MEM stage is the initiator.

Parameters:
- DEPTH_LOG2, 5: log2 of the number of 32-bit words (32 words); word index = req_addr[DEPTH_LOG2+1:2].
- LATENCY, 2: edges from request accept to response valid; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- req_be  in  4  byte-lane enables for stores; bit i covers bits [8i+7:8i]; ignored for loads
- resp_valid  out  1  response available
- resp_ready  in  1  initiator accepts the response
- resp_rdata  out  32  load data; 0 for stores
- resp_err  out  1  request rejected (see Optional Feature)

Behaviour:
- Reset (async, while rst=1):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0, latched request cleared.
  - Memory array is not cleared.
- States: IDLE, WAIT, RESP. req_ready=1 only in IDLE, decoded from the state register. Only one request is ever outstanding.
- IDLE:
  - On an edge with req_valid&req_ready, latch req_wr, word index, req_wdata and req_be.
  - Load counter with LATENCY-1 and go to WAIT.
  - No other change while req_valid=0.
- WAIT:
  - On each edge: if counter!=0, decrement it.
  - If counter==0, perform the access and go to RESP.
    - Load: resp_rdata <= mem[index].
    - Store: write only the enabled lanes, resp_rdata <= 0.
  - resp_valid <= 1 on the same edge.
- Timing: accept at edge E0 means resp_valid is high after edge E0+LATENCY.
  - Example: LATENCY=1 gives response after the next edge.
- RESP:
  - resp_valid, resp_rdata and resp_err are held stable until resp_ready=1.
  - On the handshake edge: resp_valid <= 0, resp_rdata <= 0, resp_err <= 0, go to IDLE (req_ready=1 after that edge).
  - A new request is accepted no earlier than the following edge.
- Request inputs are ignored outside IDLE. The initiator may change them freely once accepted.
- Store with req_be=4'b0000: memory unchanged; still produces a normal response.
- Address wrap: bits above DEPTH_LOG2+1 are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
- Reset mid-operation:
  - A pending store still in WAIT is discarded, with no partial write.
  - resp_valid drops immediately on rst assertion.
- resp_ready held high in IDLE/WAIT has no effect.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- Defined:
  - A request with req_addr[1:0]!=0 is still accepted and still takes LATENCY.
  - No memory access is performed.
  - Response returns resp_err=1, resp_rdata=0.
- Undefined:
  - req_addr[1:0] is ignored, the access proceeds on the word index, and resp_err is tied 0.

Test Plan:
- Reset: assert rst mid-cycle -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 immediately, before any clock edge.
- Store then load, LATENCY=2:
  - Store addr 0x08, wdata 0xA00000AA, be 4'hF accepted at E0 -> resp_valid high after E2, rdata=0.
  - Load 0x08 -> rdata=0xA00000AA after its accept edge +2.
- Byte lanes:
  - Store 0x10 = 0x11223344 (be F), then store 0x10 = 0xFFFFFFFF with be 4'b0101.
  - Load 0x10 -> 0x11FF33FF.
- Response backpressure and reset abort:
  - Hold resp_ready=0 for 5 cycles -> resp_valid and rdata stable, req_ready=0 throughout.
  - Raise resp_ready -> IDLE after one edge.
  - Separately, assert rst during WAIT of a store to 0x0C -> later load of 0x0C returns the prior value.
- Aliasing: with DEPTH_LOG2=5, store 0x84 = 0x12345678, then load 0x04 -> 0x12345678.
- Misaligned store to 0x06, wdata 0xDEADBEEF:
  - With DMEM_ALIGN_CHECK_EN defined: resp_err=1, rdata=0; load 0x04 still returns 0x12345678.
  - Without the macro: resp_err=0; load 0x04 returns 0xDEADBEEF.
